rx_block_assembler: RTL and testbench

//  Parametrised successor to the fixed 4x32->128 input shift register.

---
 rtl/rx_block_assembler_if.sv | 30 +++
 rtl/rx_block_assembler.sv | 109 ++++++++++
 tb/tb_rx_block_assembler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rx_block_assembler_if.sv
// Word-in / block-out handshake bundle for rx_block_assembler.
// Both sides are valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface rx_block_assembler_if #(
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_BLK = 4
);
  localparam int BLK_W = WORD_W * WORDS_PER_BLK;
  localparam int CNT_W = $clog2(WORDS_PER_BLK + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [BLK_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_words;
  logic [CNT_W-1:0]  fill_cnt;
  logic              state_dbg;   // 0 = FILL, 1 = HOLD

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_words, fill_cnt, state_dbg
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_words, fill_cnt, state_dbg
  );
endinterface

// File: rtl/rx_block_assembler.sv
// Gathers WORDS_PER_BLK words into one block, first word in the MSBs, with no bubble between blocks.
// Optional partial-block flush is built only when RX_ASM_FLUSH_EN is defined.
module rx_block_assembler #(
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_BLK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rx_block_assembler_if.slave  bus
);
  localparam int BLK_W = WORD_W * WORDS_PER_BLK;
  localparam int CNT_W = $clog2(WORDS_PER_BLK + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_PER_BLK - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORDS_PER_BLK);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [BLK_W-1:0] shifted;
  logic             in_ready;
  logic             accept;

  if (WORDS_PER_BLK == 1) begin : g_one_word
    assign shifted = bus.in_data;
  end else begin : g_multi_word
    assign shifted = {data_q[BLK_W-WORD_W-1:0], bus.in_data};
  end

  // In HOLD the slot frees up only as the consumer takes the block, so ready follows out_ready.
  assign in_ready = (state_q == FILL) ? 1'b1 : bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      fill_q  <= '0;
      words_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      words_q <= words_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    words_d = words_q;
    data_d  = data_q;
    if (accept) data_d = shifted;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (fill_q == LAST_IDX) begin
            state_d = HOLD;
            fill_d  = '0;
            words_d = FULL_CNT;
          end else begin
            fill_d = fill_q + CNT_W'(1);
          end
        end
`ifdef RX_ASM_FLUSH_EN
        else if (bus.flush && fill_q != '0) begin
          // Left-align the partial block; the vacated low words fill with zeros.
          state_d = HOLD;
          data_d  = data_q << ((WORDS_PER_BLK - int'(fill_q)) * WORD_W);
          words_d = fill_q;
          fill_d  = '0;
        end
`endif
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            if (WORDS_PER_BLK == 1) begin
              state_d = HOLD;
              words_d = FULL_CNT;
              fill_d  = '0;
            end else begin
              state_d = FILL;
              fill_d  = CNT_W'(1);
            end
          end else begin
            state_d = FILL;
            fill_d  = '0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

`ifndef RX_ASM_FLUSH_EN
  logic unused_flush;
  assign unused_flush = bus.flush;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_words = words_q;
  assign bus.fill_cnt  = fill_q;
  assign bus.state_dbg = (state_q == HOLD);
endmodule

// File: tb/tb_rx_block_assembler.sv
// Directed bench for rx_block_assembler (WORD_W=32, WORDS_PER_BLK=4): vector table plus a streaming scoreboard.
module tb_rx_block_assembler;
  localparam int W = 32;
  localparam int N = 4;
  localparam int B = W * N;

  typedef struct {
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         out_ready;
    logic         flush;
    logic         exp_in_ready;
    logic         exp_out_valid;
    logic [2:0]   exp_fill;
    logic         chk_data;
    logic [2:0]   exp_words;
    logic [B-1:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  logic [B-1:0] exp_q[$];

  rx_block_assembler_if #(.WORD_W(W), .WORDS_PER_BLK(N)) bus ();

  rx_block_assembler #(.WORD_W(W), .WORDS_PER_BLK(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expectations describe the outputs just after the edge on which the vector was applied.
  task automatic add(input logic r, input logic iv, input logic [W-1:0] d, input logic ordy,
                     input logic fl, input logic e_rdy, input logic e_ov, input logic [2:0] e_fill,
                     input logic chk, input logic [2:0] e_words, input logic [B-1:0] e_data);
    vec_t v;
    v.rst = r; v.in_valid = iv; v.in_data = d; v.out_ready = ordy; v.flush = fl;
    v.exp_in_ready = e_rdy; v.exp_out_valid = e_ov; v.exp_fill = e_fill;
    v.chk_data = chk; v.exp_words = e_words; v.exp_data = e_data;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic fl);
    rst = r; bus.in_valid = iv; bus.in_data = d; bus.out_ready = ordy; bus.flush = fl;
  endtask

  initial begin
    logic [B-1:0] blk;
    logic [W-1:0] w;
    int           words_in;
    int           cyc;

    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // T1 reset with in_valid asserted
    add(1, 1, 32'hDEADBEEF, 1, 0,  1, 0, 0,  1, 0, '0);
    add(1, 1, 32'hDEADBEEF, 1, 0,  1, 0, 0,  1, 0, '0);
    // T2 basic block, out_valid the cycle after the 4th accept
    add(0, 1, 32'h11111111, 1, 0,  1, 0, 1,  0, 0, '0);
    add(0, 1, 32'h22222222, 1, 0,  1, 0, 2,  0, 0, '0);
    add(0, 1, 32'h33333333, 1, 0,  1, 0, 3,  0, 0, '0);
    add(0, 1, 32'h44444444, 1, 0,  1, 1, 0,  1, 4,
        128'h11111111_22222222_33333333_44444444);
    add(0, 0, 32'h0,        1, 0,  1, 0, 0,  0, 0, '0);
    // T3 backpressure: block held for 5 cycles while B1 waits
    add(0, 1, 32'hA1A1A1A1, 0, 0,  1, 0, 1,  0, 0, '0);
    add(0, 1, 32'hA2A2A2A2, 0, 0,  1, 0, 2,  0, 0, '0);
    add(0, 1, 32'hA3A3A3A3, 0, 0,  1, 0, 3,  0, 0, '0);
    add(0, 1, 32'hA4A4A4A4, 0, 0,  0, 1, 0,  1, 4,
        128'hA1A1A1A1_A2A2A2A2_A3A3A3A3_A4A4A4A4);
    for (int i = 0; i < 5; i++)
      add(0, 1, 32'hB1B1B1B1, 0, 0,  0, 1, 0,  1, 4,
          128'hA1A1A1A1_A2A2A2A2_A3A3A3A3_A4A4A4A4);
    add(0, 1, 32'hB1B1B1B1, 1, 0,  1, 0, 1,  0, 0, '0);
    add(0, 1, 32'hB2B2B2B2, 1, 0,  1, 0, 2,  0, 0, '0);
    add(0, 1, 32'hB3B3B3B3, 1, 0,  1, 0, 3,  0, 0, '0);
    add(0, 1, 32'hB4B4B4B4, 1, 0,  1, 1, 0,  1, 4,
        128'hB1B1B1B1_B2B2B2B2_B3B3B3B3_B4B4B4B4);
    // T4 streaming 12 words straight out of HOLD: in_ready never drops
    for (int i = 0; i < 12; i++) begin
      w = 32'hC0000000 + 32'(i + 1);
      if (i % 4 == 3) begin
        blk = {32'hC0000000 + 32'(i - 2), 32'hC0000000 + 32'(i - 1),
               32'hC0000000 + 32'(i),     w};
        add(0, 1, w, 1, 0,  1, 1, 0,  1, 4, blk);
      end else begin
        add(0, 1, w, 1, 0,  1, 0, 3'((i % 4) + 1),  0, 0, '0);
      end
    end
    add(0, 0, 32'h0, 1, 0,  1, 0, 0,  0, 0, '0);
    // T5 reset mid-block discards D1, D2
    add(0, 1, 32'hD1D1D1D1, 1, 0,  1, 0, 1,  0, 0, '0);
    add(0, 1, 32'hD2D2D2D2, 1, 0,  1, 0, 2,  0, 0, '0);
    add(1, 1, 32'hDEADBEEF, 1, 0,  1, 0, 0,  1, 0, '0);
    add(0, 1, 32'hE1E1E1E1, 1, 0,  1, 0, 1,  0, 0, '0);
    add(0, 1, 32'hE2E2E2E2, 1, 0,  1, 0, 2,  0, 0, '0);
    add(0, 1, 32'hE3E3E3E3, 1, 0,  1, 0, 3,  0, 0, '0);
    add(0, 1, 32'hE4E4E4E4, 1, 0,  1, 1, 0,  1, 4,
        128'hE1E1E1E1_E2E2E2E2_E3E3E3E3_E4E4E4E4);
    add(0, 0, 32'h0, 1, 0,  1, 0, 0,  0, 0, '0);
    // T6 flush after three words
    add(0, 1, 32'hF1F1F1F1, 1, 0,  1, 0, 1,  0, 0, '0);
    add(0, 1, 32'hF2F2F2F2, 1, 0,  1, 0, 2,  0, 0, '0);
    add(0, 1, 32'hF3F3F3F3, 1, 0,  1, 0, 3,  0, 0, '0);
`ifdef RX_ASM_FLUSH_EN
    add(0, 0, 32'h0, 0, 1,  0, 1, 0,  1, 3,
        128'hF1F1F1F1_F2F2F2F2_F3F3F3F3_00000000);
    add(0, 0, 32'h0, 1, 1,  1, 0, 0,  0, 0, '0);
    add(0, 0, 32'h0, 1, 1,  1, 0, 0,  0, 0, '0);
`else
    add(0, 0, 32'h0, 0, 1,  1, 0, 3,  0, 0, '0);
    add(0, 0, 32'h0, 1, 1,  1, 0, 3,  0, 0, '0);
    add(0, 0, 32'h0, 1, 0,  1, 0, 3,  0, 0, '0);
`endif
    add(1, 0, 32'h0, 1, 0,  1, 0, 0,  1, 0, '0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready, vecs[i].flush);
      @(posedge clk);
      #1;
      check($sformatf("v%0d in_ready", i),  B'(bus.in_ready),  B'(vecs[i].exp_in_ready));
      check($sformatf("v%0d out_valid", i), B'(bus.out_valid), B'(vecs[i].exp_out_valid));
      check($sformatf("v%0d fill_cnt", i),  B'(bus.fill_cnt),  B'(vecs[i].exp_fill));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d out_words", i), B'(bus.out_words), B'(vecs[i].exp_words));
        check($sformatf("v%0d out_data", i),  bus.out_data,       vecs[i].exp_data);
      end
    end

    // Streaming with occasional consumer stalls; blocks checked against a queue.
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      exp_q.push_back({32'h50000000 + 32'(4*k + 1), 32'h50000000 + 32'(4*k + 2),
                       32'h50000000 + 32'(4*k + 3), 32'h50000000 + 32'(4*k + 4)});
    words_in = 0;
    cyc = 0;
    while ((words_in < 12 || exp_q.size() != 0) && cyc < 200) begin
      bus.out_ready = (cyc % 5 != 2);
      bus.in_valid  = (words_in < 12);
      bus.in_data   = 32'h50000000 + 32'(words_in + 1);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL stream extra block: got %h expected none", bus.out_data);
        end else begin
          check("stream block", bus.out_data, exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) words_in++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("stream drained", B'(exp_q.size()), B'(0));
    check("stream words sent", B'(words_in), B'(12));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
